// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and default widths for the ALU sequencer.
package alu_seq_pkg;
    localparam int OPW_DEF  = 3;
    localparam int CNTW_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_STORE,
        S_DONE
    } state_t;

    localparam state_t LOOP_TARGET = S_LOAD_A;
endpackage

// File: rtl/alu_sequencer_iter_counter.sv
// iter_counter: iteration counter that latches the run length and flags the last iteration.
module iter_counter #(
    parameter int CNTW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_inc,
    input  logic            i_hold,
    input  logic [CNTW-1:0] i_n,
    output logic [CNTW-1:0] o_iter,
    output logic            o_last
);
    logic [CNTW-1:0] r_iter;
    logic [CNTW-1:0] r_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_iter <= '0;
            r_n    <= '0;
        end else if (i_clr) begin
            r_iter <= '0;
            r_n    <= i_n;
        end else if (i_inc && !i_hold) begin
            r_iter <= r_iter + CNTW'(1);
        end
    end

    // Compare before incrementing so N = 2^CNTW-1 never needs iter to wrap.
    assign o_last = (r_iter + CNTW'(1)) == r_n;
    assign o_iter = r_iter;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs load-A/load-B/exec/store N times with a start/busy/done handshake and hold stall.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            CLKb,
    input  logic            RST,
    input  logic            start,
    input  logic [OPW-1:0]  op_in,
    input  logic [CNTW-1:0] count_in,
    input  logic            hold,
    output logic            enA,
    output logic            enB,
    output logic            enALU,
    output logic            enC,
    output logic [OPW-1:0]  alu_op,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] iter
);
    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_alu_op;
    logic           w_start;
    logic           w_hold;
    logic           w_last;

    assign w_start = (r_state == S_IDLE) && start;
    assign w_hold  = hold && (r_state != S_IDLE) && (r_state != S_DONE);

    iter_counter #(.CNTW(CNTW)) u_iter (
        .i_clk  (CLKb),
        .i_rst  (RST),
        .i_clr  (w_start),
        .i_inc  (r_state == S_STORE),
        .i_hold (w_hold),
        .i_n    (count_in),
        .o_iter (iter),
        .o_last (w_last)
    );

    always_comb begin
        w_next = w_hold                 ? r_state :
                 (r_state == S_IDLE)    ? (start ? ((count_in == '0) ? S_DONE : S_LOAD_A) : S_IDLE) :
                 (r_state == S_LOAD_A)  ? S_LOAD_B :
                 (r_state == S_LOAD_B)  ? S_EXEC :
                 (r_state == S_EXEC)    ? S_STORE :
                 (r_state == S_STORE)   ? (w_last ? S_DONE : LOOP_TARGET) :
                 S_IDLE;
    end

    always_ff @(posedge CLKb or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_alu_op <= '0;
        end else begin
            r_state <= w_next;
            if (w_start)
                r_alu_op <= op_in;
        end
    end

    assign enA    = (r_state == S_LOAD_A) && !hold;
    assign enB    = (r_state == S_LOAD_B) && !hold;
    assign enALU  = (r_state == S_EXEC)   && !hold;
    assign enC    = (r_state == S_STORE)  && !hold;
    assign busy   = r_state != S_IDLE;
    assign done   = r_state == S_DONE;
    assign alu_op = r_alu_op;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven directed checks of the ALU sequencer plus reset and max-count sequences.
module tb_alu_sequencer;
    localparam logic [3:0] EA = 4'b1000, EB = 4'b0100, EX = 4'b0010, EC = 4'b0001, E0 = 4'b0000;

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [3:0]  cnt;
        logic        hd;
        logic [12:0] exp;
    } vec_t;

    logic       CLKb = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] op_in = '0;
    logic [3:0] count_in = '0;
    logic       enA, enB, enALU, enC, busy, done;
    logic [2:0] alu_op;
    logic [3:0] iter;
    logic [12:0] obs;
    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    always #5 CLKb = ~CLKb;

    alu_sequencer dut (
        .CLKb     (CLKb),
        .RST      (RST),
        .start    (start),
        .op_in    (op_in),
        .count_in (count_in),
        .hold     (hold),
        .enA      (enA),
        .enB      (enB),
        .enALU    (enALU),
        .enC      (enC),
        .alu_op   (alu_op),
        .busy     (busy),
        .done     (done),
        .iter     (iter)
    );

    assign obs = {enA, enB, enALU, enC, busy, done, alu_op, iter};

    function automatic logic [12:0] ex(logic [3:0] en, logic b, logic d, logic [2:0] aop, logic [3:0] it);
        return {en, b, d, aop, it};
    endfunction

    task automatic add(logic st, logic [2:0] op, logic [3:0] cnt, logic hd, logic [12:0] e);
        vec_t v;
        v.st = st; v.op = op; v.cnt = cnt; v.hd = hd; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic check(string nm, logic [12:0] e);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got {en,busy,done,op,iter}=%b_%b_%b_%0d_%0d expected %b_%b_%b_%0d_%0d",
                     nm, obs[12:9], obs[8], obs[7], obs[6:4], obs[3:0], e[12:9], e[8], e[7], e[6:4], e[3:0]);
        end
    endtask

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    initial begin
        // basic run: op=5, N=2, done on k+9
        add(1, 3'd5, 4'd2, 0, ex(EA, 1, 0, 5, 0));
        add(0, 3'd0, 4'd0, 0, ex(EB, 1, 0, 5, 0));
        add(0, 3'd0, 4'd0, 0, ex(EX, 1, 0, 5, 0));
        add(0, 3'd0, 4'd0, 0, ex(EC, 1, 0, 5, 0));
        add(0, 3'd0, 4'd0, 0, ex(EA, 1, 0, 5, 1));
        add(0, 3'd0, 4'd0, 0, ex(EB, 1, 0, 5, 1));
        add(0, 3'd0, 4'd0, 0, ex(EX, 1, 0, 5, 1));
        add(0, 3'd0, 4'd0, 0, ex(EC, 1, 0, 5, 1));
        add(0, 3'd0, 4'd0, 0, ex(E0, 1, 1, 5, 2));
        add(0, 3'd0, 4'd0, 0, ex(E0, 0, 0, 5, 2));
        // zero-count run: done on k+1
        add(1, 3'd2, 4'd0, 0, ex(E0, 1, 1, 2, 0));
        add(0, 3'd0, 4'd0, 0, ex(E0, 0, 0, 2, 0));
        // hold for 3 edges in LOAD_B, N=1: done on k+8
        add(1, 3'd1, 4'd1, 0, ex(EA, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 0, ex(EB, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 1, ex(E0, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 1, ex(E0, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 1, ex(E0, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 0, ex(EX, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 0, ex(EC, 1, 0, 1, 0));
        add(0, 3'd0, 4'd0, 0, ex(E0, 1, 1, 1, 1));
        add(0, 3'd0, 4'd0, 0, ex(E0, 0, 0, 1, 1));
        // starts while busy and in DONE are ignored; start in first IDLE cycle accepted
        add(1, 3'd6, 4'd1, 0, ex(EA, 1, 0, 6, 0));
        add(1, 3'd7, 4'd3, 0, ex(EB, 1, 0, 6, 0));
        add(1, 3'd7, 4'd3, 0, ex(EX, 1, 0, 6, 0));
        add(0, 3'd0, 4'd0, 0, ex(EC, 1, 0, 6, 0));
        add(0, 3'd0, 4'd0, 0, ex(E0, 1, 1, 6, 1));
        add(1, 3'd7, 4'd2, 0, ex(E0, 0, 0, 6, 1));
        add(1, 3'd4, 4'd1, 0, ex(EA, 1, 0, 4, 0));
        add(0, 3'd0, 4'd0, 0, ex(EB, 1, 0, 4, 0));
        add(0, 3'd0, 4'd0, 0, ex(EX, 1, 0, 4, 0));
        add(0, 3'd0, 4'd0, 0, ex(EC, 1, 0, 4, 0));
        add(0, 3'd0, 4'd0, 0, ex(E0, 1, 1, 4, 1));
        add(0, 3'd0, 4'd0, 0, ex(E0, 0, 0, 4, 1));

        tick();
        check("reset_values", ex(E0, 0, 0, 0, 0));
        RST = 1'b0;

        foreach (vq[i]) begin
            start = vq[i].st; op_in = vq[i].op; count_in = vq[i].cnt; hold = vq[i].hd;
            tick();
            check($sformatf("vec%0d", i), vq[i].exp);
        end
        start = 1'b0; hold = 1'b0;

        // maximum count: 15 iterations, done at k+61, iter stops at 15
        start = 1'b1; op_in = 3'd3; count_in = 4'd15;
        for (int i = 0; i < 60; i++) begin
            tick();
            start = 1'b0;
            check($sformatf("max_c%0d", i + 1), ex(EA >> (i % 4), 1, 0, 3, 4'(i / 4)));
        end
        tick();
        check("max_done", ex(E0, 1, 1, 3, 15));
        tick();
        check("max_idle", ex(E0, 0, 0, 3, 15));

        // asynchronous reset mid-run in EXEC with iter=2
        start = 1'b1; op_in = 3'd5; count_in = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_reset_exec", ex(EX, 1, 0, 5, 2));
        #2 RST = 1'b1;
        #1 check("reset_midrun", ex(E0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_held%0d", i), ex(E0, 0, 0, 0, 0));
        end
        RST = 1'b0; start = 1'b1; op_in = 3'd1; count_in = 4'd1;
        tick();
        start = 1'b0;
        check("start_after_reset", ex(EA, 1, 0, 1, 0));
        for (int i = 0; i < 4; i++) tick();
        check("post_reset_done", ex(E0, 1, 1, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
